// File: rtl/spi_rx_buffer.sv
// rtl/spi_rx_buffer.sv - receive-side byte FIFO between spi_master and a consumer
//
// Purpose:
//   Buffers bytes strobed out of spi_master while slave select is active.
//   Reads have a 1-cycle latency: rd_data/rd_valid appear the cycle after rd_en.
//   A push into a full FIFO is dropped and sets a sticky overflow flag, unless a
//   pop is accepted in the same cycle, which frees the slot.
//
// Optional feature (macro SPI_RX_FRAME_LEN_EN):
//   Counts the bytes accepted during each ss-low frame, saturating at 255.
//   When ss rises, the count is reported on frame_len and frame_done pulses.
//   Without the macro, frame_done and frame_len are tied to 0.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, >= 4)
//   AW         log2(DEPTH)
//
// Ports:
//   clk        in   rising-edge clock shared with spi_master / spi_mode_config
//   rst        in   asynchronous active-low reset
//   new_data   in   one-cycle strobe: data_out holds a received byte
//   data_out   in   [7:0] received byte
//   ss         in   slave select, active-low (low = frame active)
//   rd_en      in   consumer pop request
//   clr_ovf    in   clears the sticky overflow flag
//   rd_data    out  [7:0] popped byte (registered)
//   rd_valid   out  one-cycle pulse qualifying rd_data
//   empty      out  FIFO holds 0 entries
//   full       out  FIFO holds DEPTH entries
//   count      out  [AW:0] occupancy 0..DEPTH
//   ovf        out  sticky: a byte was dropped
//   frame_done out  one-cycle pulse at frame end
//   frame_len  out  [7:0] bytes accepted in the last completed frame

module spi_rx_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_data,
  input  logic [7:0]    data_out,
  input  logic          ss,
  input  logic          rd_en,
  input  logic          clr_ovf,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          frame_done,
  output logic [7:0]    frame_len
);

  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ZERO = '0;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  // Storage: not reset, contents are only meaningful between the pointers.
  logic [7:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          empty_q,  empty_d;
  logic          full_q,   full_d;
  logic          ovf_q,    ovf_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic push_req;
  logic pop_acc;
  logic push_acc;
  logic drop;

  // A pop is only ever accepted from a non-empty FIFO, so a simultaneous
  // push+pop on an empty FIFO accepts just the push (no fall-through), and a
  // push into a full FIFO survives only if a pop frees a slot in that cycle.
  always_comb begin
    push_req = new_data & ~ss;
    pop_acc  = rd_en & ~empty_q;
    push_acc = push_req & (~full_q | pop_acc);
    drop     = push_req & full_q & ~pop_acc;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (pop_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Flags come from the next count so all three stay consistent each cycle.
    empty_d = (count_d == CNT_ZERO);
    full_d  = (count_d == CNT_FULL);

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= data_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign ovf      = ovf_q;

`ifdef SPI_RX_FRAME_LEN_EN
  logic       ss_q,         ss_d;
  logic [7:0] frame_cnt_q,  frame_cnt_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] frame_len_q,  frame_len_d;
  logic       ss_rise;
  logic       ss_fall;

  // Only accepted pushes advance the counter; push_acc already implies ss=0,
  // so a byte strobed in the cycle ss rises is never counted.
  always_comb begin
    ss_d         = ss;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    ss_rise      = ss & ~ss_q;
    ss_fall      = ~ss & ss_q;

    if (ss_fall) begin
      // A byte accepted in the very first frame cycle still belongs to it.
      frame_cnt_d = push_acc ? 8'd1 : 8'd0;
    end else if (push_acc && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if (ss_rise) begin
      frame_len_d  = frame_cnt_q;
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_q         <= 1'b1;
      frame_cnt_q  <= 8'd0;
      frame_done_q <= 1'b0;
      frame_len_q  <= 8'd0;
    end else begin
      ss_q         <= ss_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
    end
  end

  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
`else
  assign frame_done = 1'b0;
  assign frame_len  = 8'h00;
`endif

endmodule

// File: tb/tb_spi_rx_buffer.sv
// tb/tb_spi_rx_buffer.sv - self-checking bench for spi_rx_buffer

module tb_spi_rx_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

`ifdef SPI_RX_FRAME_LEN_EN
  localparam int EXP_FD     = 1;
  localparam int EXP_LEN5   = 5;
  localparam int EXP_LEN255 = 255;
`else
  localparam int EXP_FD     = 0;
  localparam int EXP_LEN5   = 0;
  localparam int EXP_LEN255 = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          new_data;
  logic [7:0]    data_out;
  logic          ss;
  logic          rd_en;
  logic          clr_ovf;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          ovf;
  logic          frame_done;
  logic [7:0]    frame_len;

  spi_rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .new_data   (new_data),
    .data_out   (data_out),
    .ss         (ss),
    .rd_en      (rd_en),
    .clr_ovf    (clr_ovf),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .ovf        (ovf),
    .frame_done (frame_done),
    .frame_len  (frame_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       nd;
    logic [7:0] d;
    logic       ss;
    logic       rd;
    logic       clr;
    int         cnt;
    logic       ovf;
    logic       push_ok;
    logic       pop;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  logic [7:0] exp_rd;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic vec_t mk(input logic nd, input logic [7:0] d, input logic s,
                              input logic rd, input logic clr, input int cnt,
                              input logic o, input logic pok, input logic pop);
    vec_t v;
    v.nd = nd; v.d = d; v.ss = s; v.rd = rd; v.clr = clr;
    v.cnt = cnt; v.ovf = o; v.push_ok = pok; v.pop = pop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    new_data = v.nd;
    data_out = v.d;
    ss       = v.ss;
    rd_en    = v.rd;
    clr_ovf  = v.clr;
    if (v.push_ok) sb.push_back(v.d);
    @(posedge clk);
    #1;
    new_data = 1'b0;
    rd_en    = 1'b0;
    clr_ovf  = 1'b0;
    chk("count", 32'(count), 32'(v.cnt));
    chk("empty", 32'(empty), 32'(v.cnt == 0));
    chk("full", 32'(full), 32'(v.cnt == DEPTH));
    chk("ovf", 32'(ovf), 32'(v.ovf));
    chk("rd_valid", 32'(rd_valid), 32'(v.pop));
    if (v.pop) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: pop expected but no byte queued");
      end else begin
        exp_rd = sb.pop_front();
      end
    end
    chk("rd_data", 32'(rd_data), 32'(exp_rd));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_len"}, 32'(frame_len), 0);
  endtask

  initial begin
    // ---- vector table ----
    // two-byte push then two pops
    vecs.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1));
    // strobes with ss high are ignored, pop on empty is ignored
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 8'hC0 + 8'(i), 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0));
    // push+pop on empty: only the push lands; push+pop mid-fill keeps count
    vecs.push_back(mk(1, 8'h55, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 8'h66, 0, 1, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1));
    // fill to full, drop, clear, push+pop at full, drain across pointer wrap
    for (int i = 0; i < DEPTH; i++) vecs.push_back(mk(1, 8'(i), 0, 0, 0, i + 1, 0, 1, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0, 0, DEPTH, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, DEPTH, 0, 0, 0));
    vecs.push_back(mk(1, 8'h77, 0, 1, 0, DEPTH, 0, 1, 1));
    for (int i = 0; i < DEPTH; i++) vecs.push_back(mk(0, 8'h00, 0, 1, 0, DEPTH - 1 - i, 0, 0, 1));
    // drop coinciding with clr_ovf: the drop wins
    for (int i = 0; i < DEPTH; i++) vecs.push_back(mk(1, 8'h80 + 8'(i), 0, 0, 0, i + 1, 0, 1, 0));
    vecs.push_back(mk(1, 8'hEE, 0, 0, 1, DEPTH, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, DEPTH, 0, 0, 0));
    for (int i = 0; i < DEPTH; i++) vecs.push_back(mk(0, 8'h00, 0, 1, 0, DEPTH - 1 - i, 0, 0, 1));

    // ---- reset ----
    rst = 1'b1; new_data = 1'b0; data_out = 8'h00; ss = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
    exp_rd = 8'h00;
    #2 rst = 1'b0;
    #1 chk_reset_vals("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ss = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // ---- frame length: 5-byte frame, strobe on the rising-ss cycle ignored ----
    step(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) step(mk(1, 8'h21 + 8'(i), 0, 0, 0, i + 1, 0, 1, 0));
    step(mk(1, 8'hBB, 1, 0, 0, 5, 0, 0, 0));
    chk("frame_done_5", 32'(frame_done), 32'(EXP_FD));
    chk("frame_len_5", 32'(frame_len), 32'(EXP_LEN5));
    step(mk(0, 8'h00, 1, 0, 0, 5, 0, 0, 0));
    chk("frame_done_pulse", 32'(frame_done), 0);
    chk("frame_len_hold", 32'(frame_len), 32'(EXP_LEN5));
    for (int i = 0; i < 5; i++) step(mk(0, 8'h00, 1, 1, 0, 4 - i, 0, 0, 1));

    // ---- 300-byte frame with concurrent pops: length saturates ----
    step(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 8'h00, 0, 1, 0, 1, 0, 1, 0));
    for (int i = 1; i < 300; i++) step(mk(1, 8'(i), 0, 1, 0, 1, 0, 1, 1));
    step(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1));
    step(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0));
    chk("frame_done_300", 32'(frame_done), 32'(EXP_FD));
    chk("frame_len_300", 32'(frame_len), 32'(EXP_LEN255));

    // ---- reset asserted mid-pop discards contents ----
    step(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(mk(1, 8'h41 + 8'(i), 0, 0, 0, i + 1, 0, 1, 0));
    rd_en = 1'b1;
    #2 rst = 1'b0;
    #1 chk_reset_vals("midpop");
    @(posedge clk);
    #1 rst = 1'b1;
    rd_en = 1'b0;
    sb.delete();
    exp_rd = 8'h00;
    step(mk(1, 8'h11, 0, 0, 0, 1, 0, 1, 0));
    step(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1));
    chk("post_reset_byte", 32'(rd_data), 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_rx_buffer.md
SPI_RX_BUFFER -- requirements
Module: spi_rx_buffer

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries; SHALL be a power of two, minimum 4.
REQ-002 Parameter AW, default 4: address width; SHALL equal log2(DEPTH).
REQ-003 clk  in  1  single clock (same as spi_master / spi_mode_config); all logic SHALL be rising-edge clocked.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 new_data  in  1  one-cycle strobe from spi_master: byte received.
REQ-006 data_out  in  8  received byte from spi_master; valid when new_data=1.
REQ-007 ss  in  1  slave select from spi_mode_config, active-low; low = frame active.
REQ-008 rd_en  in  1  consumer pop request.
REQ-009 clr_ovf  in  1  clears sticky overflow flag.
REQ-010 rd_data  out  8  popped byte, registered.
REQ-011 rd_valid  out  1  rd_data valid; one-cycle pulse.
REQ-012 empty  out  1  FIFO holds 0 entries.
REQ-013 full  out  1  FIFO holds DEPTH entries.
REQ-014 count  out  AW+1  current occupancy, 0..DEPTH.
REQ-015 ovf  out  1  sticky: a byte was dropped.
REQ-016 frame_done  out  1  one-cycle pulse on frame end (only with SPI_RX_FRAME_LEN_EN).
REQ-017 frame_len  out  8  bytes accepted in last completed frame (only with SPI_RX_FRAME_LEN_EN).

Function
REQ-018 Push condition: new_data=1 and ss=0; byte data_out SHALL be written at wr_ptr and wr_ptr SHALL increment modulo DEPTH.
REQ-019 new_data while ss=1 SHALL be ignored: no write, no ovf.
REQ-020 Push while full and no simultaneous accepted pop: byte SHALL be dropped, ovf set at next edge, count unchanged.
REQ-021 Pop condition: rd_en=1 and empty=0; rd_data SHALL update and rd_valid pulse high on the following cycle (1-cycle latency); rd_ptr increments modulo DEPTH.
REQ-022 rd_en while empty SHALL be ignored; rd_valid stays 0, rd_data holds its value.
REQ-023 Simultaneous push and pop when full: both SHALL be accepted, count stays DEPTH, ovf not set.
REQ-024 Simultaneous push and pop when empty: only push accepted (no fall-through); count becomes 1.
REQ-025 Simultaneous push and pop otherwise: both accepted, count unchanged.
REQ-026 count, empty, full SHALL be registered and consistent with each other in every cycle; pointer wrap SHALL not disturb them.
REQ-027 clr_ovf=1 SHALL clear ovf next edge; if a drop occurs in the same cycle, ovf SHALL remain set (set wins).

Reset
REQ-028 rst low SHALL asynchronously clear: pointers, count=0, empty=1, full=0, ovf=0, rd_data=8'h00, rd_valid=0, frame_done=0, frame_len=0, frame counter=0, ss history register=1.
REQ-029 Reset asserted mid-frame or mid-pop SHALL discard all stored bytes; after release the first accepted push SHALL land at entry 0.
REQ-030 Memory array contents need not be reset.

Configuration
REQ-031 Macro SPI_RX_FRAME_LEN_EN defined: internal 8-bit counter SHALL count accepted pushes while ss=0, saturating at 255; on ss 0->1 edge (detected against registered ss) frame_len SHALL load the counter and frame_done pulse one cycle; counter clears on ss 1->0.
REQ-032 A push accepted in the same cycle ss rises SHALL be ignored per REQ-019 (ss already 1); dropped bytes SHALL not be counted.
REQ-033 Macro undefined: frame counter and edge detect SHALL be absent; frame_done and frame_len SHALL be tied to 0.

Verification
REQ-034 Reset, ss=0, push 8'hA5,8'h3C, then rd_en two cycles -> rd_data A5 then 3C with rd_valid each cycle after rd_en; empty=1, count=0 at end.
REQ-035 Push 16 bytes (00..0F) with ss=0 -> full=1, count=16; push 8'hFF -> dropped, ovf=1; pop all -> 00..0F in order; clr_ovf -> ovf=0.
REQ-036 Full FIFO, push 8'h77 and rd_en same cycle -> count stays 16, ovf=0; after draining, 8'h77 is last byte out.
REQ-037 ss=1, pulse new_data 3 times -> count=0, ovf=0; rd_en on empty -> rd_valid stays 0.
REQ-038 With SPI_RX_FRAME_LEN_EN: ss low, push 5 bytes, ss high -> frame_done one cycle, frame_len=5; 300-byte frame with concurrent pops -> frame_len=255.
REQ-039 Push 3 bytes, assert rst low mid-pop for 1 cycle -> all outputs at reset values immediately; after release push 8'h11 and pop -> rd_data=11, count returns to 0.
